operand_fetch: RTL and testbench

//  ID->EX operand stage directly downstream of the 32x32 register file (r0 hard-wired 0).

---
 rtl/cpu_pkg.sv | 18 +
 rtl/operand_fetch_if.sv | 62 ++++++
 rtl/fwd_mux.sv | 54 +++++
 rtl/operand_fetch.sv | 104 ++++++++++
 tb/tb_operand_fetch.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the operand-fetch stage.
//   DW        datapath / register width
//   AW        register-number width (r0 is constant zero)
//   fwd_sel_t source chosen for one operand, lowest to highest priority
package cpu_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef enum logic [2:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX,
        FWD_ZERO
    } fwd_sel_t;

endpackage

// File: rtl/operand_fetch_if.sv
// ID/EX operand-fetch bus: ID-stage instruction fields, regfile read port,
// bypass tags/data from EX/MEM/WB, pipeline control and the ID/EX register.
//   slave  : operand-fetch stage side
//   master : surrounding pipeline side
interface operand_fetch_if #(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
);
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [AW-1:0] id_wn;
    logic          id_wreg;
    logic          id_m2reg;

    logic [AW-1:0] rna;
    logic [AW-1:0] rnb;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;

    logic [DW-1:0] ex_res;
    logic [AW-1:0] mem_wn;
    logic          mem_wreg;
    logic [DW-1:0] mem_res;
    logic [AW-1:0] wb_wn;
    logic          wb_we;
    logic [DW-1:0] wb_d;

    logic          flush;
    logic          ex_hold;
    logic          stall;

    logic          ex_valid;
    logic          ex_wreg;
    logic          ex_m2reg;
    logic [AW-1:0] ex_wn;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wn, id_wreg, id_m2reg,
        output rna, rnb,
        input  qa, qb,
        input  ex_res, mem_wn, mem_wreg, mem_res, wb_wn, wb_we, wb_d,
        input  flush, ex_hold,
        output stall,
        output ex_valid, ex_wreg, ex_m2reg, ex_wn, ex_a, ex_b
    );

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wn, id_wreg, id_m2reg,
        input  rna, rnb,
        output qa, qb,
        output ex_res, mem_wn, mem_wreg, mem_res, wb_wn, wb_we, wb_d,
        output flush, ex_hold,
        input  stall,
        input  ex_valid, ex_wreg, ex_m2reg, ex_wn, ex_a, ex_b
    );

endinterface

// File: rtl/fwd_mux.sv
// Per-operand bypass selector.
//   r, rd_use                register number and whether the operand is read
//   ex_*, mem_*, wb_*        destination tags and result data of later stages
//   rf_d                     regfile read data
//   val, sel                 resolved operand and the source that supplied it
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [AW-1:0] r,
    input  logic          rd_use,
    input  logic          ex_valid,
    input  logic          ex_wreg,
    input  logic          ex_m2reg,
    input  logic [AW-1:0] ex_wn,
    input  logic [DW-1:0] ex_res,
    input  logic          mem_wreg,
    input  logic [AW-1:0] mem_wn,
    input  logic [DW-1:0] mem_res,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_wn,
    input  logic [DW-1:0] wb_d,
    input  logic [DW-1:0] rf_d,
    output logic [DW-1:0] val,
    output fwd_sel_t      sel
);

    always_comb begin
        sel = FWD_RF;
        if (rd_use) begin
            if (r == '0)
                sel = FWD_ZERO;
            // a load in EX has no data yet; the load-use stall covers it
            else if (ex_valid && ex_wreg && !ex_m2reg && ex_wn == r)
                sel = FWD_EX;
            else if (mem_wreg && mem_wn == r)
                sel = FWD_MEM;
            // regfile is written on the same edge we capture, so qa/qb are stale
            else if (wb_we && wb_wn == r)
                sel = FWD_WB;
        end
    end

    always_comb begin
        val = rf_d;
        case (sel)
            FWD_ZERO: val = '0;
            FWD_EX:   val = ex_res;
            FWD_MEM:  val = mem_res;
            FWD_WB:   val = wb_d;
            default:  val = rf_d;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// ID->EX operand stage: regfile read addressing, operand bypass, load-use
// hazard detection and the ID/EX pipeline register.
//   clk, clrn       clock and asynchronous active-low reset
//   bus             operand_fetch_if slave (ID fields, regfile, bypass, ID/EX)
//   stall_cnt       saturating count of load-use bubbles
//   sel_a, sel_b    bypass source chosen per operand
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            clrn,
    operand_fetch_if.slave  bus,
    output logic [CNTW-1:0] stall_cnt,
    output fwd_sel_t        sel_a,
    output fwd_sel_t        sel_b
);

    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic          luse;

    assign bus.rna = bus.id_rs;
    assign bus.rnb = bus.id_rt;

    fwd_mux u_fwd_a (
        .r        (bus.id_rs),
        .rd_use   (bus.id_use_rs),
        .ex_valid (bus.ex_valid),
        .ex_wreg  (bus.ex_wreg),
        .ex_m2reg (bus.ex_m2reg),
        .ex_wn    (bus.ex_wn),
        .ex_res   (bus.ex_res),
        .mem_wreg (bus.mem_wreg),
        .mem_wn   (bus.mem_wn),
        .mem_res  (bus.mem_res),
        .wb_we    (bus.wb_we),
        .wb_wn    (bus.wb_wn),
        .wb_d     (bus.wb_d),
        .rf_d     (bus.qa),
        .val      (fwd_a),
        .sel      (sel_a)
    );

    fwd_mux u_fwd_b (
        .r        (bus.id_rt),
        .rd_use   (bus.id_use_rt),
        .ex_valid (bus.ex_valid),
        .ex_wreg  (bus.ex_wreg),
        .ex_m2reg (bus.ex_m2reg),
        .ex_wn    (bus.ex_wn),
        .ex_res   (bus.ex_res),
        .mem_wreg (bus.mem_wreg),
        .mem_wn   (bus.mem_wn),
        .mem_res  (bus.mem_res),
        .wb_we    (bus.wb_we),
        .wb_wn    (bus.wb_wn),
        .wb_d     (bus.wb_d),
        .rf_d     (bus.qb),
        .val      (fwd_b),
        .sel      (sel_b)
    );

    always_comb begin
        luse = bus.id_valid && bus.ex_valid && bus.ex_m2reg && bus.ex_wreg
            && (bus.ex_wn != '0)
            && ((bus.id_use_rs && bus.id_rs == bus.ex_wn)
             || (bus.id_use_rt && bus.id_rt == bus.ex_wn));
    end

    assign bus.stall = bus.ex_hold | luse;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bus.ex_valid <= 1'b0;
            bus.ex_wreg  <= 1'b0;
            bus.ex_m2reg <= 1'b0;
            bus.ex_wn    <= '0;
            bus.ex_a     <= '0;
            bus.ex_b     <= '0;
            stall_cnt    <= '0;
        end else if (bus.flush) begin
            // data fields are dead once ex_valid drops
            bus.ex_valid <= 1'b0;
        end else if (bus.ex_hold) begin
            bus.ex_valid <= bus.ex_valid;
        end else if (luse) begin
            // one bubble: the load moves to MEM and is bypassed from mem_res next cycle
            bus.ex_valid <= 1'b0;
            bus.ex_wreg  <= 1'b0;
            if (stall_cnt != '1)
                stall_cnt <= stall_cnt + CNTW'(1);
        end else begin
            bus.ex_valid <= bus.id_valid;
            bus.ex_wn    <= bus.id_wn;
            bus.ex_wreg  <= bus.id_wreg && (bus.id_wn != '0);
            bus.ex_m2reg <= bus.id_m2reg;
            bus.ex_a     <= fwd_a;
            bus.ex_b     <= fwd_b;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: stimulus steps push expected values
// tagged with the cycle they become observable; a monitor compares them at
// each falling edge (or on demand for the asynchronous-reset check).
module tb_operand_fetch;
    import cpu_pkg::*;

    // narrow counter so saturation is reachable in a short run
    localparam int CNTW = 6;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            clrn;
    logic [CNTW-1:0] stall_cnt;
    fwd_sel_t        sel_a;
    fwd_sel_t        sel_b;

    operand_fetch_if bus ();

    operand_fetch #(.CNTW(CNTW)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .bus       (bus.slave),
        .stall_cnt (stall_cnt),
        .sel_a     (sel_a),
        .sel_b     (sel_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {F_STALL, F_VALID, F_WREG, F_WN, F_A, F_B, F_CNT, F_SELA} fld_t;
    typedef struct {
        string       name;
        fld_t        f;
        logic [31:0] v;
        int          due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    event snap;

    function automatic logic [31:0] actual(fld_t f);
        case (f)
            F_STALL: return 32'(bus.stall);
            F_VALID: return 32'(bus.ex_valid);
            F_WREG:  return 32'(bus.ex_wreg);
            F_WN:    return 32'(bus.ex_wn);
            F_A:     return bus.ex_a;
            F_B:     return bus.ex_b;
            F_CNT:   return 32'(stall_cnt);
            F_SELA:  return 32'(sel_a);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic check_due();
        exp_t        e;
        logic [31:0] got;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e   = q.pop_front();
            got = actual(e.f);
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, got, e.v, cyc);
            end
        end
    endtask

    always @(negedge clk) check_due();
    always @(snap) check_due();

    task automatic expect_v(string nm, fld_t f, logic [31:0] v, int off);
        exp_t e;
        e.name = nm;
        e.f    = f;
        e.v    = v;
        e.due  = cyc + off;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.id_valid  = 1'b0;
        bus.id_rs     = '0;
        bus.id_rt     = '0;
        bus.id_use_rs = 1'b0;
        bus.id_use_rt = 1'b0;
        bus.id_wn     = '0;
        bus.id_wreg   = 1'b0;
        bus.id_m2reg  = 1'b0;
        bus.qa        = '0;
        bus.qb        = '0;
        bus.ex_res    = '0;
        bus.mem_wn    = '0;
        bus.mem_wreg  = 1'b0;
        bus.mem_res   = '0;
        bus.wb_wn     = '0;
        bus.wb_we     = 1'b0;
        bus.wb_d      = '0;
        bus.flush     = 1'b0;
        bus.ex_hold   = 1'b0;
    endtask

    task automatic load_r5();
        tick();
        clear();
        bus.id_valid = 1'b1;
        bus.id_wn    = 5'd5;
        bus.id_wreg  = 1'b1;
        bus.id_m2reg = 1'b1;
    endtask

    task automatic use_r5_rt();
        tick();
        clear();
        bus.id_valid  = 1'b1;
        bus.id_rt     = 5'd5;
        bus.id_use_rt = 1'b1;
        bus.id_wn     = 5'd9;
        bus.id_wreg   = 1'b1;
    endtask

    int model_cnt;

    initial begin
        clear();
        clrn = 1'b0;
        tick();
        expect_v("rst_valid", F_VALID, 0, 0);
        expect_v("rst_wreg",  F_WREG,  0, 0);
        expect_v("rst_wn",    F_WN,    0, 0);
        expect_v("rst_a",     F_A,     0, 0);
        expect_v("rst_b",     F_B,     0, 0);
        expect_v("rst_cnt",   F_CNT,   0, 0);
        tick();
        clrn = 1'b1;

        // MEM beats WB on rs; rt comes from the regfile
        tick();
        clear();
        bus.id_valid = 1'b1; bus.id_wn = 5'd7; bus.id_wreg = 1'b1;
        bus.id_rs = 5'd3; bus.id_use_rs = 1'b1; bus.id_rt = 5'd4; bus.id_use_rt = 1'b1;
        bus.qa = 32'hAAAA_0003; bus.qb = 32'hBBBB_0004;
        bus.mem_wn = 5'd3; bus.mem_wreg = 1'b1; bus.mem_res = 32'h11;
        bus.wb_wn = 5'd3; bus.wb_we = 1'b1; bus.wb_d = 32'h22;
        expect_v("mem_wb_stall", F_STALL, 0, 0);
        expect_v("mem_wb_sel",   F_SELA,  32'(FWD_MEM), 0);
        expect_v("mem_wb_a",     F_A,     32'h11, 1);
        expect_v("rf_b",         F_B,     32'hBBBB_0004, 1);
        expect_v("t1_valid",     F_VALID, 1, 1);
        expect_v("t1_wn",        F_WN,    7, 1);
        expect_v("t1_wreg",      F_WREG,  1, 1);

        // EX beats MEM on rs; WB-only on rt; destination r0 forces wreg low
        tick();
        clear();
        bus.id_valid = 1'b1; bus.id_wn = 5'd0; bus.id_wreg = 1'b1;
        bus.id_rs = 5'd7; bus.id_use_rs = 1'b1; bus.id_rt = 5'd9; bus.id_use_rt = 1'b1;
        bus.qa = 32'hAAAA_0007; bus.qb = 32'hBBBB_0009;
        bus.ex_res = 32'h77;
        bus.mem_wn = 5'd7; bus.mem_wreg = 1'b1; bus.mem_res = 32'h55;
        bus.wb_wn = 5'd9; bus.wb_we = 1'b1; bus.wb_d = 32'h99;
        expect_v("ex_sel",    F_SELA, 32'(FWD_EX), 0);
        expect_v("ex_a",      F_A,    32'h77, 1);
        expect_v("wb_b",      F_B,    32'h99, 1);
        expect_v("r0_wreg",   F_WREG, 0, 1);

        // r0 reads zero despite MEM/WB targeting it; lw r5 enters ID/EX
        tick();
        clear();
        bus.id_valid = 1'b1; bus.id_wn = 5'd5; bus.id_wreg = 1'b1; bus.id_m2reg = 1'b1;
        bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
        bus.qa = 32'h123; bus.qb = 32'h456; bus.ex_res = 32'h77;
        bus.mem_wn = 5'd0; bus.mem_wreg = 1'b1; bus.mem_res = 32'h5;
        bus.wb_wn = 5'd0; bus.wb_we = 1'b1; bus.wb_d = 32'h6;
        expect_v("r0_stall", F_STALL, 0, 0);
        expect_v("r0_sel",   F_SELA,  32'(FWD_ZERO), 0);
        expect_v("r0_a",     F_A,     0, 1);
        expect_v("r0_b",     F_B,     0, 1);
        expect_v("lw_wn",    F_WN,    5, 1);

        // load-use on rt: one bubble
        tick();
        clear();
        bus.id_valid = 1'b1; bus.id_wn = 5'd6; bus.id_wreg = 1'b1;
        bus.id_rs = 5'd2; bus.id_use_rs = 1'b1; bus.id_rt = 5'd5; bus.id_use_rt = 1'b1;
        bus.qa = 32'h2; bus.qb = 32'hBAD;
        expect_v("luse_stall",  F_STALL, 1, 0);
        expect_v("luse_bubble", F_VALID, 0, 1);
        expect_v("luse_wreg",   F_WREG,  0, 1);
        expect_v("luse_cnt",    F_CNT,   1, 1);

        // same instruction retried; load now in MEM
        tick();
        clear();
        bus.id_valid = 1'b1; bus.id_wn = 5'd6; bus.id_wreg = 1'b1;
        bus.id_rs = 5'd2; bus.id_use_rs = 1'b1; bus.id_rt = 5'd5; bus.id_use_rt = 1'b1;
        bus.qa = 32'h2; bus.qb = 32'hBAD;
        bus.mem_wn = 5'd5; bus.mem_wreg = 1'b1; bus.mem_res = 32'hDEAD;
        expect_v("retry_stall", F_STALL, 0, 0);
        expect_v("retry_b",     F_B,     32'hDEAD, 1);
        expect_v("retry_a",     F_A,     32'h2, 1);
        expect_v("retry_valid", F_VALID, 1, 1);
        expect_v("retry_wn",    F_WN,    6, 1);
        expect_v("retry_cnt",   F_CNT,   1, 1);

        // rt matches the load but is not read: no stall
        load_r5();
        expect_v("lw2_valid", F_VALID, 1, 1);
        tick();
        clear();
        bus.id_valid = 1'b1; bus.id_wn = 5'd8; bus.id_wreg = 1'b1;
        bus.id_rs = 5'd1; bus.id_use_rs = 1'b1; bus.id_rt = 5'd5;
        bus.qa = 32'h31;
        expect_v("nouse_stall", F_STALL, 0, 0);
        expect_v("nouse_valid", F_VALID, 1, 1);
        expect_v("nouse_a",     F_A,     32'h31, 1);
        expect_v("nouse_cnt",   F_CNT,   1, 1);

        // ex_hold for 3 cycles with a load-use pending, then flush under hold
        load_r5();
        for (int i = 0; i < 3; i++) begin
            use_r5_rt();
            bus.ex_hold = 1'b1;
            expect_v("hold_stall", F_STALL, 1, 0);
            expect_v("hold_valid", F_VALID, 1, 1);
            expect_v("hold_wn",    F_WN,    5, 1);
            expect_v("hold_cnt",   F_CNT,   1, 1);
        end
        use_r5_rt();
        bus.ex_hold = 1'b1;
        bus.flush   = 1'b1;
        expect_v("flush_stall", F_STALL, 1, 0);
        expect_v("flush_valid", F_VALID, 0, 1);
        expect_v("flush_cnt",   F_CNT,   1, 1);

        tick();
        clear();
        bus.id_valid = 1'b1; bus.id_wn = 5'd9; bus.id_wreg = 1'b1;
        bus.id_rt = 5'd5; bus.id_use_rt = 1'b1; bus.qb = 32'h5555;
        expect_v("post_flush_stall", F_STALL, 0, 0);
        expect_v("post_flush_b",     F_B,     32'h5555, 1);
        expect_v("post_flush_valid", F_VALID, 1, 1);

        // drive the counter into saturation and a few bubbles beyond
        model_cnt = 1;
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            load_r5();
            use_r5_rt();
            if (model_cnt < CNT_MAX) model_cnt++;
            expect_v("sat_stall", F_STALL, 1, 0);
            expect_v("sat_cnt",   F_CNT,   32'(model_cnt), 1);
        end

        // async reset in the middle of a load-use stall
        load_r5();
        use_r5_rt();
        expect_v("pre_rst_stall", F_STALL, 1, 0);
        @(negedge clk);
        #1;
        clrn = 1'b0;
        #1;
        expect_v("arst_valid", F_VALID, 0, 0);
        expect_v("arst_wreg",  F_WREG,  0, 0);
        expect_v("arst_wn",    F_WN,    0, 0);
        expect_v("arst_a",     F_A,     0, 0);
        expect_v("arst_b",     F_B,     0, 0);
        expect_v("arst_cnt",   F_CNT,   0, 0);
        expect_v("arst_stall", F_STALL, 0, 0);
        ->snap;
        #1;
        tick();
        clear();
        clrn = 1'b1;
        expect_v("post_rst_cnt", F_CNT, 0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
